// File: rtl/fifo_burst_rd_ctrl.sv
// Burst read controller: waits for a full burst in the frame FIFO, issues a DDR
// write command, then drains BURST_LEN words through a 2-entry skid buffer.
module fifo_burst_rd_ctrl #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    LEVEL_WIDTH = 15,
  parameter int                    ADDR_WIDTH  = 28,
  parameter int                    BURST_LEN   = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BYTES = 28'h0096000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [ADDR_WIDTH-1:0]  cmd_addr,
  output logic [7:0]             cmd_len,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic                   wr_last,
  output logic                   busy
);

  localparam int CW          = 9;
  localparam int BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
  localparam logic [LEVEL_WIDTH-1:0] LVL_BURST = LEVEL_WIDTH'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0]    FRAME_END = {1'b0, BASE_ADDR} + {1'b0, FRAME_BYTES};
  localparam logic [ADDR_WIDTH:0]    ADDR_STEP = (ADDR_WIDTH+1)'(BURST_BYTES);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                         state, state_nxt;
  logic [ADDR_WIDTH-1:0]          addr;
  logic [ADDR_WIDTH:0]            addr_sum;
  logic [CW-1:0]                  rd_cnt, tx_cnt;
  logic [1:0][DATA_WIDTH-1:0]     skid;
  logic [1:0]                     buf_cnt;
  logic [2:0]                     occ;
  logic                           inflight, pending;
  logic                           push, pop, cmd_hs, last_hs, restart;

  assign push     = inflight;
  assign wr_valid = buf_cnt != 2'd0;
  assign pop      = wr_valid & wr_ready;
  assign wr_data  = skid[0];
  assign wr_last  = wr_valid & (tx_cnt == CW'(BURST_LEN - 1));
  assign last_hs  = pop & wr_last;
  assign cmd_hs   = cmd_valid & cmd_ready;
  assign cmd_addr = addr;
  assign cmd_len  = 8'(BURST_LEN - 1);
  assign restart  = frame_start | pending;
  assign addr_sum = {1'b0, addr} + ADDR_STEP;

  // Occupancy after this cycle's pop; counting the pop keeps one beat per cycle
  // while still guaranteeing the returning word always has a free slot.
  assign occ = {1'b0, buf_cnt} - {2'b0, pop} + {2'b0, inflight};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!restart && fifo_rd_water_level >= LVL_BURST) state_nxt = CMD;
      CMD:     if (cmd_ready) state_nxt = DATA;
      DATA:    if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_valid  = 1'b0;
    busy       = 1'b0;
    fifo_rd_en = 1'b0;
    case (state)
      CMD: begin
        cmd_valid = 1'b1;
        busy      = 1'b1;
      end
      DATA: begin
        busy       = 1'b1;
        fifo_rd_en = (rd_cnt < CW'(BURST_LEN)) & ~fifo_rd_empty & (occ < 3'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      buf_cnt  <= '0;
      skid     <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (push && !pop) begin
        skid[buf_cnt[0]] <= fifo_rd_data;
        buf_cnt          <= buf_cnt + 2'd1;
      end else if (pop && !push) begin
        skid[0] <= skid[1];
        buf_cnt <= buf_cnt - 2'd1;
      end else if (push && pop) begin
        if (buf_cnt == 2'd1) begin
          skid[0] <= fifo_rd_data;
        end else begin
          skid[0] <= skid[1];
          skid[1] <= fifo_rd_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      tx_cnt <= '0;
    end else if (cmd_hs) begin
      rd_cnt <= '0;
      tx_cnt <= '0;
    end else begin
      if (fifo_rd_en) rd_cnt <= rd_cnt + CW'(1);
      if (pop)        tx_cnt <= tx_cnt + CW'(1);
    end
  end

  // A frame_start seen mid-burst is deferred so the burst in flight keeps its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr    <= BASE_ADDR;
      pending <= 1'b0;
    end else if (state == IDLE && restart) begin
      addr    <= BASE_ADDR;
      pending <= 1'b0;
    end else begin
      if (frame_start) pending <= 1'b1;
      if (last_hs)     addr    <= (addr_sum >= FRAME_END) ? BASE_ADDR : addr_sum[ADDR_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Scoreboard bench for fifo_burst_rd_ctrl with a behavioural 1-cycle-latency FIFO.
module tb_fifo_burst_rd_ctrl;
  localparam int BL = 64;

  logic        clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0;
  logic        fifo_rd_en, fifo_rd_empty;
  logic [15:0] fifo_rd_data = '0;
  logic [14:0] lvl = '0;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic [27:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [15:0] wr_data;
  logic        wr_valid, wr_ready = 1'b0, wr_last, busy;
  logic        gate = 1'b0;

  int checks = 0, errors = 0;
  int beat = 0, bursts = 0, rd_pulses = 0, cmds = 0;
  logic [15:0] fq[$], exp_q[$], mon_d;
  logic [27:0] exp_addr[$], mon_a;

  fifo_burst_rd_ctrl #(
    .DATA_WIDTH(16), .LEVEL_WIDTH(15), .ADDR_WIDTH(28), .BURST_LEN(BL),
    .BASE_ADDR(28'h0), .FRAME_BYTES(28'h200)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_water_level(lvl),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_last(wr_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign fifo_rd_empty = (lvl == 15'd0) || gate;

  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
    lvl <= 15'(fq.size());
  end

  // Scoreboard monitor: commands and beats are checked against queued expectations.
  always @(negedge clk) begin
    if (!rst_n) begin
      beat = 0;
    end else begin
      if (fifo_rd_en) rd_pulses++;
      if (cmd_valid && cmd_ready) begin
        checks++;
        cmds++;
        if (exp_addr.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: got addr %h, required no command", cmd_addr);
        end else begin
          mon_a = exp_addr.pop_front();
          if (cmd_addr !== mon_a || cmd_len !== 8'd63) begin
            errors++;
            $display("FAIL cmd: got addr %h len %0d, required addr %h len 63", cmd_addr, cmd_len, mon_a);
          end
        end
      end
      if (wr_valid && wr_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got data %h, required no beat", wr_data);
        end else begin
          mon_d = exp_q.pop_front();
          if (wr_data !== mon_d || wr_last !== (beat == BL-1)) begin
            errors++;
            $display("FAIL beat %0d: got data %h last %b, required data %h last %b",
                     beat, wr_data, wr_last, mon_d, (beat == BL-1));
          end
        end
        if (beat == BL-1) begin
          beat = 0;
          bursts++;
        end else beat++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      fq.push_back(16'(base + i));
      exp_q.push_back(16'(base + i));
    end
    lvl = 15'(fq.size());
  endtask

  task automatic wait_bursts(input int target, input string name);
    int n = 0;
    while (bursts < target && n < 3000) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (bursts < target) begin
      errors++;
      $display("FAIL %s_timeout: got %0d bursts, required %0d", name, bursts, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 8;
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b, required 0", fifo_rd_en); end
    if (cmd_valid !== 1'b0)  begin errors++; $display("FAIL reset_cmd_valid: got %b, required 0", cmd_valid); end
    if (wr_valid !== 1'b0)   begin errors++; $display("FAIL reset_wr_valid: got %b, required 0", wr_valid); end
    if (wr_last !== 1'b0)    begin errors++; $display("FAIL reset_wr_last: got %b, required 0", wr_last); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (cmd_addr !== 28'h0)  begin errors++; $display("FAIL reset_cmd_addr: got %h, required 0", cmd_addr); end
    if (cmd_len !== 8'd63)   begin errors++; $display("FAIL reset_cmd_len: got %0d, required 63", cmd_len); end
    if (wr_data !== 16'h0)   begin errors++; $display("FAIL reset_wr_data: got %h, required 0", wr_data); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    cmd_ready = 1'b1;
    wr_ready  = 1'b1;
    rd_pulses = 0;
    exp_addr.push_back(28'h0);
    load(BL, 0);
    wait_bursts(1, "basic");
    checks += 4;
    if (rd_pulses !== BL)    begin errors++; $display("FAIL basic_rd_pulses: got %0d, required %0d", rd_pulses, BL); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL basic_idle: got busy %b, required 0", busy); end
    if (cmds !== 1)          begin errors++; $display("FAIL basic_cmds: got %0d, required 1", cmds); end
    if (exp_q.size() !== 0)  begin errors++; $display("FAIL basic_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_threshold();
    int seen = 0;
    int n = 0;
    exp_addr.push_back(28'h80);
    load(BL-1, 1000);
    repeat (100) begin
      tick();
      if (cmd_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL threshold_63: got %0d cmd cycles, required 0", seen); end
    load(1, 1000 + BL-1);
    while (!cmd_valid && n < 3) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_valid !== 1'b1 || n > 2) begin
      errors++;
      $display("FAIL threshold_64: got cmd_valid %b after %0d cycles, required 1 within 2", cmd_valid, n);
    end
    wait_bursts(2, "threshold");
  endtask

  task automatic test_backpressure();
    int n = 0;
    exp_addr.push_back(28'h100);
    load(BL, 2000);
    while (bursts < 3 && n < 3000) begin
      tick();
      wr_ready = 1'($urandom_range(0, 1));
      n++;
    end
    wr_ready = 1'b1;
    tick();
    checks += 2;
    if (bursts !== 3)       begin errors++; $display("FAIL backpressure_done: got %0d bursts, required 3", bursts); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL backpressure_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_empty_stall();
    int n = 0;
    int idle = 0;
    rd_pulses = 0;
    exp_addr.push_back(28'h180);
    load(BL, 3000);
    while (rd_pulses < 30 && n < 500) begin
      tick();
      n++;
    end
    gate = 1'b1;
    repeat (20) begin
      tick();
      if (!wr_valid) idle++;
    end
    checks += 3;
    if (rd_pulses !== 30) begin errors++; $display("FAIL stall_reads: got %0d, required 30", rd_pulses); end
    if (idle == 0)        begin errors++; $display("FAIL stall_gap: got %0d idle cycles, required >0", idle); end
    if (beat !== 30)      begin errors++; $display("FAIL stall_beats: got %0d, required 30", beat); end
    gate = 1'b0;
    wait_bursts(4, "stall");
  endtask

  task automatic test_wrap_frame();
    int n = 0;
    exp_addr.push_back(28'h0);
    load(BL, 4000);
    wait_bursts(5, "wrap");
    exp_addr.push_back(28'h80);
    load(BL, 5000);
    while (beat < 10 && n < 500) begin
      tick();
      n++;
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_bursts(6, "frame_mid");
    exp_addr.push_back(28'h0);
    load(BL, 6000);
    wait_bursts(7, "frame_next");
    checks++;
    if (cmds !== 7) begin errors++; $display("FAIL wrap_cmds: got %0d, required 7", cmds); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    exp_addr.push_back(28'h80);
    load(BL, 7000);
    while (beat < 20 && n < 500) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state: got busy %b cmd_valid %b, required 0 0", busy, cmd_valid);
    end
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_mid_rd_en: got %b, required 0", fifo_rd_en); end
    if (wr_valid !== 1'b0 || wr_last !== 1'b0) begin
      errors++; $display("FAIL rst_mid_stream: got valid %b last %b, required 0 0", wr_valid, wr_last);
    end
    if (cmd_addr !== 28'h0) begin errors++; $display("FAIL rst_mid_addr: got %h, required 0", cmd_addr); end
    if (wr_data !== 16'h0)  begin errors++; $display("FAIL rst_mid_data: got %h, required 0", wr_data); end
    fq.delete();
    exp_q.delete();
    lvl = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    exp_addr.push_back(28'h0);
    load(BL, 8000);
    wait_bursts(8, "after_reset");
    checks++;
    if (exp_addr.size() !== 0) begin errors++; $display("FAIL addr_queue: got %0d unissued, required 0", exp_addr.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_threshold();
    test_backpressure();
    test_empty_stall();
    test_wrap_frame();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
